core_rr_arbiter: RTL and testbench

//  Round-robin arbiter for the shared memory port; sits directly downstream of find_id_core.

---
 rtl/core_rr_arbiter.sv | 109 ++++++++++
 tb/tb_core_rr_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/core_rr_arbiter.sv
// Round-robin arbiter for the shared memory port: a rotating priority search
// picks the next requester after the last one served, then holds a registered grant.
`ifndef NUM_OF_CORES
`define NUM_OF_CORES 4
`endif
`ifndef CORE_ID_SIZE
`define CORE_ID_SIZE 2
`endif

// Circular priority search: first set bit of mask strictly after start_search,
// wrapping so start_search itself is examined last. result[IDW]=1 means none found.
module find_id_core #(
    parameter int N   = `NUM_OF_CORES,
    parameter int IDW = `CORE_ID_SIZE
) (
    input  logic [N-1:0]   mask,
    input  logic [IDW-1:0] start_search,
    output logic [IDW:0]   result
);
    always_comb begin
        result = {1'b1, {IDW{1'b0}}};
        // Walk from the farthest offset inward so the nearest hit overwrites.
        for (int k = N; k >= 1; k--) begin
            int unsigned idx;
            idx = (int'(start_search) + k) % N;
            if (mask[idx])
                result = {1'b0, IDW'(idx)};
        end
    end
endmodule

module core_rr_arbiter #(
    parameter int MAX_HOLD = 255,
    parameter int HOLD_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [`NUM_OF_CORES-1:0]   req,
    input  logic [`NUM_OF_CORES-1:0]   done,
    input  logic                       stall,
    output logic [`NUM_OF_CORES-1:0]   grant,
    output logic [`CORE_ID_SIZE-1:0]   grant_id,
    output logic                       grant_valid,
    output logic                       timeout
);
    localparam int N   = `NUM_OF_CORES;
    localparam int IDW = `CORE_ID_SIZE;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    logic [IDW-1:0]    last_id;
    logic [HOLD_W-1:0] hold_cnt;
    logic [IDW:0]      result;
    logic              release_now;
    logic              force_rel;

    find_id_core #(.N(N), .IDW(IDW)) u_find (
        .mask         (req),
        .start_search (last_id),
        .result       (result)
    );

    // An explicit release always wins over the hold limit, so no timeout pulse then.
    assign release_now = done[grant_id] | ~req[grant_id];
    assign force_rel   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            hold_cnt    <= '0;
            last_id     <= IDW'(N - 1);
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (!result[IDW] && !stall) begin
                        grant       <= {{(N-1){1'b0}}, 1'b1} << result[IDW-1:0];
                        grant_id    <= result[IDW-1:0];
                        grant_valid <= 1'b1;
                        last_id     <= result[IDW-1:0];
                        hold_cnt    <= '0;
                        state       <= BUSY;
                    end else begin
                        grant       <= '0;
                        grant_id    <= '0;
                        grant_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    if (hold_cnt != {HOLD_W{1'b1}})
                        hold_cnt <= hold_cnt + 1'b1;
                    if (release_now || force_rel) begin
                        grant       <= '0;
                        grant_id    <= '0;
                        grant_valid <= 1'b0;
                        timeout     <= ~release_now;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_core_rr_arbiter.sv
// Directed bench for core_rr_arbiter: rotation, stall, hold timeout, stray done, async reset.
module tb_core_rr_arbiter;
    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] done;
    logic       stall;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    int vectors = 0;
    int miscompares = 0;

    core_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .stall       (stall),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                           input logic ev, input logic eto);
        chk({tag, ".grant"}, 32'(grant), 32'(eg));
        chk({tag, ".grant_id"}, 32'(grant_id), 32'(eid));
        chk({tag, ".grant_valid"}, 32'(grant_valid), 32'(ev));
        chk({tag, ".timeout"}, 32'(timeout), 32'(eto));
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        done  = '0;
        stall = 1'b0;
        tick;
        tick;
        chk_out("rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        chk("rst.last_id", 32'(dut.last_id), 32'd3);
        reset = 1'b0;

        // 1: idle with no requests
        for (int i = 0; i < 5; i++) begin
            tick;
            chk_out("t1.idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        end
        chk("t1.last_id", 32'(dut.last_id), 32'd3);

        // 2: all request, rotation 0,1,2,3,0 with one-cycle gaps
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            logic [1:0] id;
            id = 2'(i % 4);
            tick;
            chk_out("t2.grant", 4'b0001 << id, id, 1'b1, 1'b0);
            done = 4'b0001 << id;
            tick;
            done = '0;
            chk_out("t2.gap", 4'b0000, 2'd0, 1'b0, 1'b0);
        end
        req = '0;

        // 3: stall blocks arbitration
        req   = 4'b0100;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk_out("t3.stall", 4'b0000, 2'd0, 1'b0, 1'b0);
        end
        stall = 1'b0;
        tick;
        chk_out("t3.grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = '0;
        tick;
        chk_out("t3.drop", 4'b0000, 2'd0, 1'b0, 1'b0);

        // 4: hold limit of 4 cycles forces release, then single requester re-granted
        req = 4'b0010;
        tick;
        chk_out("t4.grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk_out("t4.hold", 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        tick;
        chk_out("t4.timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick;
        chk_out("t4.regrant", 4'b0010, 2'd1, 1'b1, 1'b0);

        // done coinciding with the hold limit is a normal release
        for (int i = 0; i < 3; i++) begin
            tick;
            chk_out("t7.hold", 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        done = 4'b0010;
        tick;
        chk_out("t7.done_at_limit", 4'b0000, 2'd0, 1'b0, 1'b0);
        done = '0;
        req  = '0;
        tick;
        chk_out("t7.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // 5: done on a non-granted core is ignored
        req = 4'b1001;
        tick;
        chk_out("t5.grant3", 4'b1000, 2'd3, 1'b1, 1'b0);
        done = 4'b0001;
        tick;
        chk_out("t5.stray_done", 4'b1000, 2'd3, 1'b1, 1'b0);
        done = 4'b1000;
        tick;
        chk_out("t5.release", 4'b0000, 2'd0, 1'b0, 1'b0);
        done = '0;
        tick;
        chk_out("t5.grant0", 4'b0001, 2'd0, 1'b1, 1'b0);

        // 6: asynchronous reset while busy
        #2;
        reset = 1'b1;
        #1;
        chk_out("t6.async", 4'b0000, 2'd0, 1'b0, 1'b0);
        chk("t6.last_id", 32'(dut.last_id), 32'd3);
        tick;
        reset = 1'b0;
        chk_out("t6.in_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick;
        chk_out("t6.first", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = '0;
        tick;
        chk_out("t6.drop", 4'b0000, 2'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
